// File: rtl/mem_burst_ctrl.sv
// Burst master for the 16-bit valid/ready memory: one command, N single-beat accesses, address wrap at DEPTH.
// Optional RESP watchdog enabled by defining MEM_BURST_TIMEOUT_EN.
module mem_burst_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 6,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wdata_valid_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  wdata_ready_o,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      rd_data_o,
  input  logic                  rd_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic                  mem_wr_rd_o,
  output logic                  mem_valid_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WFETCH = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_RHOLD  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]            state_q;
  logic                  wr_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [LEN_WIDTH:0]    beats_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  bad_addr;
  logic                  last_beat;

`ifdef MEM_BURST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  assign bad_addr  = ({1'b0, cmd_addr_i} >= (ADDR_WIDTH+1)'(DEPTH));
  assign addr_nxt  = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
  assign last_beat = (beats_q == (LEN_WIDTH+1)'(1));

  // Handshake outputs come from the state register alone, so no input reaches an output combinationally.
  assign cmd_ready_o   = (state_q == S_IDLE);
  assign wdata_ready_o = (state_q == S_WFETCH);
  assign mem_valid_o   = (state_q == S_ISSUE);
  assign rd_valid_o    = (state_q == S_RHOLD);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = (state_q == S_DONE) && err_q;
  assign mem_addr_o    = addr_q;
  assign mem_wr_rd_o   = wr_q;
  assign mem_wdata_o   = wdata_q;
  assign rd_data_o     = rd_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      beats_q   <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
`ifdef MEM_BURST_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            wr_q    <= cmd_wr_i;
            addr_q  <= cmd_addr_i;
            beats_q <= {1'b0, cmd_len_i} + (LEN_WIDTH+1)'(1);
            err_q   <= bad_addr;
            if (bad_addr)      state_q <= S_DONE;
            else if (cmd_wr_i) state_q <= S_WFETCH;
            else               state_q <= S_ISSUE;
          end
        end
        S_WFETCH: begin
          if (wdata_valid_i) begin
            wdata_q <= wdata_i;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_RESP;
`ifdef MEM_BURST_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        S_RESP: begin
          if (mem_ready_i) begin
            if (!wr_q) begin
              rd_data_q <= mem_rdata_i;
              state_q   <= S_RHOLD;
            end else if (last_beat) begin
              state_q <= S_DONE;
            end else begin
              beats_q <= beats_q - (LEN_WIDTH+1)'(1);
              addr_q  <= addr_nxt;
              state_q <= S_WFETCH;
            end
          end
`ifdef MEM_BURST_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        S_RHOLD: begin
          if (rd_ready_i) begin
            if (last_beat) begin
              state_q <= S_DONE;
            end else begin
              beats_q <= beats_q - (LEN_WIDTH+1)'(1);
              addr_q  <= addr_nxt;
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl with a behavioural single-beat memory; honours MEM_BURST_TIMEOUT_EN.
module tb_mem_burst_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_wr_i;
  logic [15:0] cmd_addr_i;
  logic [5:0]  cmd_len_i;
  logic        wdata_valid_i, wdata_ready_o;
  logic [15:0] wdata_i;
  logic        rd_valid_o, rd_ready_i;
  logic [15:0] rd_data_o;
  logic [15:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_wr_rd_o, mem_valid_o, mem_ready_i;
  logic        done_o, err_o;

  logic        mem_en;
  logic [15:0] mem [0:63];

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_rd_q[$];
  logic        exp_err_q[$];

  always #5 clk_i = ~clk_i;

  mem_burst_ctrl #(.WIDTH(16), .DEPTH(64), .ADDR_WIDTH(16), .LEN_WIDTH(6), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wr_rd_o(mem_wr_rd_o),
    .mem_valid_o(mem_valid_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .done_o(done_o), .err_o(err_o)
  );

  // Memory answers on the edge that samples valid; mem_en=0 models an unresponsive memory.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_ready_i <= 1'b0;
      mem_rdata_i <= '0;
    end else begin
      mem_ready_i <= mem_valid_o && mem_en;
      if (mem_valid_o && mem_en) begin
        if (mem_wr_rd_o) mem[mem_addr_o[5:0]] <= mem_wdata_o;
        else             mem_rdata_i <= mem[mem_addr_o[5:0]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(negedge clk_i) begin
    #1;
    if (mem_valid_o) begin
      if (exp_addr_q.size() == 0) unexpected("mem_access");
      else chk("mem_addr", mem_addr_o, exp_addr_q.pop_front());
    end
    if (rd_valid_o && rd_ready_i) begin
      if (exp_rd_q.size() == 0) unexpected("rd_beat");
      else chk("rd_data", rd_data_o, exp_rd_q.pop_front());
    end
    if (done_o) begin
      if (exp_err_q.size() == 0) unexpected("done");
      else chk("done_err", err_o, exp_err_q.pop_front());
    end else if (err_o) begin
      unexpected("err_without_done");
    end
  end

  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [5:0] len);
    int n = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && n < 100) begin @(negedge clk_i); n++; end
    chk("cmd_ready_wait", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = addr; cmd_len_i = len;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_wdata(input logic [15:0] w);
    int n = 0;
    wdata_valid_i = 1'b1; wdata_i = w;
    while (!wdata_ready_o && n < 100) begin @(negedge clk_i); n++; end
    chk("wdata_ready_wait", wdata_ready_o, 1);
    @(negedge clk_i);
    wdata_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 1;
    while (!done_o && n < bound) begin @(negedge clk_i); n++; end
    chk("done_wait", done_o, 1);
    @(negedge clk_i);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
    chk({tag, "_mem_valid"}, mem_valid_o, 0);
    chk({tag, "_wdata_ready"}, wdata_ready_o, 0);
    chk({tag, "_rd_valid"}, rd_valid_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_wr_rd"}, mem_wr_rd_o, 0);
    chk({tag, "_rd_data"}, rd_data_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0; rd_ready_i = 1'b1; mem_en = 1'b1;
    @(negedge clk_i); @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_i = 1'b1;

    // Write then read back 4 beats at address 2.
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(16'(2 + i));
    exp_err_q.push_back(1'b0);
    send_cmd(1'b1, 16'd2, 6'd3);
    for (int i = 0; i < 4; i++) send_wdata(16'hA000 + 16'(i));
    wait_done(100, n);
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(16'(2 + i));
      exp_rd_q.push_back(16'hA000 + 16'(i));
    end
    exp_err_q.push_back(1'b0);
    send_cmd(1'b0, 16'd2, 6'd3);
    wait_done(100, n);
    chk("read_latency", n, 13);

    // Wrap at DEPTH: 62, 63, 0, 1.
    exp_addr_q.push_back(16'd62); exp_addr_q.push_back(16'd63);
    exp_addr_q.push_back(16'd0);  exp_addr_q.push_back(16'd1);
    exp_err_q.push_back(1'b0);
    send_cmd(1'b1, 16'd62, 6'd3);
    for (int i = 0; i < 4; i++) send_wdata(16'hB000 + 16'(i));
    wait_done(100, n);
    exp_addr_q.push_back(16'd62); exp_addr_q.push_back(16'd63);
    exp_addr_q.push_back(16'd0);  exp_addr_q.push_back(16'd1);
    for (int i = 0; i < 4; i++) exp_rd_q.push_back(16'hB000 + 16'(i));
    exp_err_q.push_back(1'b0);
    send_cmd(1'b0, 16'd62, 6'd3);
    wait_done(100, n);

    // Downstream stall on beat 0 of a 2-beat read.
    rd_ready_i = 1'b0;
    exp_addr_q.push_back(16'd2); exp_addr_q.push_back(16'd3);
    exp_rd_q.push_back(16'hA000); exp_rd_q.push_back(16'hA001);
    exp_err_q.push_back(1'b0);
    send_cmd(1'b0, 16'd2, 6'd1);
    n = 0;
    while (!rd_valid_o && n < 50) begin @(negedge clk_i); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_rd_valid", rd_valid_o, 1);
      chk("stall_rd_data", rd_data_o, 16'hA000);
      chk("stall_mem_valid", mem_valid_o, 0);
      @(negedge clk_i);
    end
    rd_ready_i = 1'b1;
    wait_done(100, n);

    // Start address at DEPTH: immediate error, no memory access.
    exp_err_q.push_back(1'b1);
    send_cmd(1'b0, 16'd64, 6'd0);
    wait_done(10, n);
    chk("bad_addr_latency", n, 1);
    chk("bad_addr_cmd_ready", cmd_ready_o, 1);
    chk("bad_addr_done_clear", done_o, 0);

    // Asynchronous reset while beat 1 of a write is being issued.
    exp_addr_q.push_back(16'd10); exp_addr_q.push_back(16'd11);
    send_cmd(1'b1, 16'd10, 6'd3);
    send_wdata(16'hC000);
    send_wdata(16'hC001);
    #2 rst_i = 1'b0;
    #1 chk_reset_outputs("midburst");
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;
    exp_addr_q.push_back(16'd2); exp_rd_q.push_back(16'hA000); exp_err_q.push_back(1'b0);
    send_cmd(1'b0, 16'd2, 6'd0);
    wait_done(20, n);
    chk("post_reset_latency", n, 4);

    // Unresponsive memory.
    mem_en = 1'b0;
    exp_addr_q.push_back(16'd3);
`ifdef MEM_BURST_TIMEOUT_EN
    exp_err_q.push_back(1'b1);
    send_cmd(1'b0, 16'd3, 6'd1);
    wait_done(100, n);
    chk("timeout_latency", n, 17);
    mem_en = 1'b1;
`else
    send_cmd(1'b0, 16'd3, 6'd1);
    d = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_o) d++;
      @(negedge clk_i);
    end
    chk("hang_no_done", d, 0);
    chk("hang_cmd_ready", cmd_ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_en = 1'b1;
`endif

    repeat (3) @(negedge clk_i);
    chk("addr_queue_empty", exp_addr_q.size(), 0);
    chk("rd_queue_empty", exp_rd_q.size(), 0);
    chk("done_queue_empty", exp_err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
